pipeline_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage RV32 pipeline. Drives the

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_event_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    TRAP_FLUSH = 1'b1
  } haz_state_t;

  // Encoding the fetch register inserts when it is flushed (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Hard-wired zero register; never a real data dependency
  localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/hazard_event_counter.sv
// Free-running event counter for hazard statistics; wraps modulo 2^CNT_W.
module hazard_event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count one per cycle in which inc is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline.
// Owns all hold/kill decisions for the fetch, decode and execute registers:
// load-use stalls, taken-branch bubbles, data-memory wait stalls and the
// multi-cycle flush that follows an accepted trap or mret.
// Optional build macro: HAZ_PERF_EN enables stall/flush/trap perf counters;
// when undefined the counter ports are tied to zero.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TRAP_FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rd_E,
  input  logic             mem_read_E,
  input  logic             branch_taken_E,
  input  logic             mem_busy,
  input  logic             trap_req,
  input  logic             mret_M,
  output logic             trap_ack,
  output logic             stall_F,
  output logic             flush_F,
  output logic             csr_flush,
  output logic             stall_D,
  output logic             flush_E,
  output logic             pc_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] trap_cnt
);

  localparam int unsigned FW = (TRAP_FLUSH_CYCLES > 1) ? $clog2(TRAP_FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(TRAP_FLUSH_CYCLES - 1);

  haz_state_t    state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          load_use;

  // Decode-stage operand depends on a load still in execute
  assign load_use = mem_read_E && (rd_E != REG_X0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // State and trap-flush cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state and Mealy outputs; in RUN exactly one action wins by priority
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    trap_ack  = 1'b0;
    stall_F   = 1'b0;
    flush_F   = 1'b0;
    csr_flush = 1'b0;
    stall_D   = 1'b0;
    flush_E   = 1'b0;
    pc_hold   = 1'b0;
    case (state)
      RUN: begin
        if ((trap_req || mret_M) && !mem_busy) begin
          trap_ack  = 1'b1;
          state_nxt = TRAP_FLUSH;
          fcnt_nxt  = '0;
        end else if (mem_busy) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          pc_hold = 1'b1;
        end else if (branch_taken_E) begin
          // PC is free to take the branch target while fetch gets a NOP
          stall_F = 1'b1;
          flush_F = 1'b1;
          flush_E = 1'b1;
        end else if (load_use) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          pc_hold = 1'b1;
          flush_E = 1'b1;
        end
      end
      TRAP_FLUSH: begin
        // PC loads mtvec/mepc; new trap/mret requests wait until RUN
        csr_flush = 1'b1;
        flush_E   = 1'b1;
        if (fcnt == FLUSH_LAST) begin
          state_nxt = RUN;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt + FW'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = '0;
      end
    endcase
  end

`ifdef HAZ_PERF_EN
  hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_F),
    .cnt (stall_cnt)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_E),
    .cnt (flush_cnt)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_trap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (trap_ack),
    .cnt (trap_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign trap_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Output vector order: {trap_ack, stall_F, flush_F, csr_flush, stall_D, flush_E, pc_hold}
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] O_IDLE = 7'b000_0000;
  localparam logic [6:0] O_ACK  = 7'b100_0000;
  localparam logic [6:0] O_BUSY = 7'b010_0101;
  localparam logic [6:0] O_BR   = 7'b011_0010;
  localparam logic [6:0] O_LU   = 7'b010_0111;
  localparam logic [6:0] O_TF   = 7'b000_1010;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1_D, rs2_D, rd_E;
  logic             mem_read_E, branch_taken_E, mem_busy, trap_req, mret_M;
  logic             trap_ack, stall_F, flush_F, csr_flush, stall_D, flush_E, pc_hold;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, trap_cnt;

  logic [31:0]      instr_in;
  logic [31:0]      fetch_q;
  logic [6:0]       outs;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TRAP_FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .rd_E           (rd_E),
    .mem_read_E     (mem_read_E),
    .branch_taken_E (branch_taken_E),
    .mem_busy       (mem_busy),
    .trap_req       (trap_req),
    .mret_M         (mret_M),
    .trap_ack       (trap_ack),
    .stall_F        (stall_F),
    .flush_F        (flush_F),
    .csr_flush      (csr_flush),
    .stall_D        (stall_D),
    .flush_E        (flush_E),
    .pc_hold        (pc_hold),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .trap_cnt       (trap_cnt)
  );

  assign outs = {trap_ack, stall_F, flush_F, csr_flush, stall_D, flush_E, pc_hold};

  // Fetch register as the pipeline wires it: flush inserts a NOP, stall holds
  always @(posedge clk or posedge rst) begin
    if (rst)          fetch_q <= '0;
    else if (flush_F) fetch_q <= NOP_INSTR;
    else if (!stall_F) fetch_q <= instr_in;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample combinational outputs mid-cycle
  task automatic sample(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check(tag, 64'(outs), 64'(exp));
  endtask

  task automatic idle_inputs();
    rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
    mem_read_E = 1'b0; branch_taken_E = 1'b0; mem_busy = 1'b0;
    trap_req = 1'b0; mret_M = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    mem_read_E = 1'b1; rd_E = rd; rs1_D = r1; rs2_D = r2;
  endtask

  initial begin
    rst = 1'b1;
    instr_in = 32'h00a00093;
    idle_inputs();

    // Reset state
    #2;
    check("reset_outs", 64'(outs), 64'(O_IDLE));
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample("run_idle", O_IDLE);
    next_cycle();
    check("fetch_loads", 64'(fetch_q), 64'h00a00093);

    // Load-use on rs1, rs2, then non-hazards
    set_load_use(5'd5, 5'd5, 5'd9);
    sample("lu_rs1", O_LU);
    next_cycle();
    set_load_use(5'd7, 5'd3, 5'd7);
    sample("lu_rs2", O_LU);
    next_cycle();
    set_load_use(5'd0, 5'd0, 5'd0);
    sample("lu_x0", O_IDLE);
    next_cycle();
    set_load_use(5'd5, 5'd6, 5'd7);
    sample("lu_nomatch", O_IDLE);
    next_cycle();
    idle_inputs();
    rd_E = 5'd5; rs1_D = 5'd5;
    sample("lu_not_load", O_IDLE);
    next_cycle();

    // Taken branch, fetch register sees the NOP next cycle
    idle_inputs();
    instr_in = 32'h12345678;
    next_cycle();
    check("fetch_before_br", 64'(fetch_q), 64'h12345678);
    branch_taken_E = 1'b1;
    sample("branch", O_BR);
    next_cycle();
    branch_taken_E = 1'b0;
    check("fetch_nop", 64'(fetch_q), 64'(NOP_INSTR));
    sample("after_branch", O_IDLE);
    next_cycle();

    // Trap: ack pulse, two flush cycles ignoring new requests, back to RUN
    trap_req = 1'b1;
    sample("trap_ack", O_ACK);
    next_cycle();
    mem_busy = 1'b1;
    sample("trap_flush0", O_TF);
    next_cycle();
    idle_inputs();
    sample("trap_flush1", O_TF);
    next_cycle();
    sample("trap_done", O_IDLE);
    next_cycle();

    // Trap held off by mem_busy for three cycles
    trap_req = 1'b1;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample($sformatf("trap_busy%0d", i), O_BUSY);
      next_cycle();
    end
    mem_busy = 1'b0;
    sample("trap_busy_ack", O_ACK);
    next_cycle();
    trap_req = 1'b0;
    sample("trap_busy_f0", O_TF);
    next_cycle();
    sample("trap_busy_f1", O_TF);
    next_cycle();
    sample("trap_busy_done", O_IDLE);
    next_cycle();

    // mret takes the same path
    mret_M = 1'b1;
    sample("mret_ack", O_ACK);
    next_cycle();
    mret_M = 1'b0;
    sample("mret_f0", O_TF);
    next_cycle();
    next_cycle();

    // Priority: mem_busy beats branch and load-use; branch beats load-use
    branch_taken_E = 1'b1;
    set_load_use(5'd4, 5'd4, 5'd0);
    mem_busy = 1'b1;
    sample("prio_busy", O_BUSY);
    next_cycle();
    mem_busy = 1'b0;
    sample("prio_branch", O_BR);
    next_cycle();
    idle_inputs();

    // Asynchronous reset in the second flush cycle
    trap_req = 1'b1;
    sample("rst_trap_ack", O_ACK);
    next_cycle();
    trap_req = 1'b0;
    sample("rst_trap_f0", O_TF);
    next_cycle();
    rst = 1'b1;
    #1;
    check("rst_mid_flush", 64'(outs), 64'(O_IDLE));
    next_cycle();
    rst = 1'b0;
    sample("rst_run", O_IDLE);
    next_cycle();

    // Three load-use events for the perf counters
    for (int i = 0; i < 3; i++) begin
      set_load_use(5'd5, 5'd5, 5'd0);
      next_cycle();
      idle_inputs();
      next_cycle();
    end
    @(negedge clk);
`ifdef HAZ_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'd3);
    check("flush_cnt", 64'(flush_cnt), 64'd3);
    check("trap_cnt",  64'(trap_cnt),  64'd0);
`else
    check("stall_cnt_tied", 64'(stall_cnt), 64'd0);
    check("flush_cnt_tied", 64'(flush_cnt), 64'd0);
    check("trap_cnt_tied",  64'(trap_cnt),  64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run in case the sequence stalls
  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
